if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_stage_if_id_reg.sv | 84 ++++++++
 rtl/if_stage.sv | 98 +++++++++
 tb/tb_if_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: constants shared by the fetch stage and its IF/ID register.
//   - CP0 ExcCode values for the exceptions the pipeline can raise.
//   - Default reset PC, exception entry address and legal fetch window.
// Optional feature: IF_RANGE_CHECK_EN (see if_stage.sv) uses IM_LO/IM_HI.
package if_stage_pkg;

    localparam logic [4:0] EXC_NONE    = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] PKG_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] PKG_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] PKG_IM_LO      = 32'h0000_3000;
    localparam logic [31:0] PKG_IM_HI      = 32'h0000_6FFC;

    // Word alignment check for a fetch address.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register bank.
// Ports:
//   clk, reset        - clock (rising edge), async active-high reset
//   req               - CP0 exception/interrupt redirect (highest priority)
//   stall             - hold all registers
//   flush             - squash the slot being fetched (Eret)
//   if_pc             - current fetch PC
//   fetch_instr       - checked instruction word (0 on AdEL)
//   fetch_exc         - fetch ExcCode (AdEL or 0)
//   is_jump           - decode instruction is a branch/jump
//   id_pc, id_instr, id_exc_code, id_bd - registered outputs to decode
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = PKG_RESET_PC,
    parameter logic [31:0] HANDLER_PC = PKG_HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] if_pc,
    input  logic [31:0] fetch_instr,
    input  logic [4:0]  fetch_exc,
    input  logic        is_jump,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [4:0]  id_exc_code,
    output logic        id_bd
);

    logic [31:0] pc_d, pc_q;
    logic [31:0] instr_d, instr_q;
    logic [4:0]  exc_d, exc_q;
    logic        bd_d, bd_q;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        if (req) begin
            // Bubble tagged with the handler address so CP0 sees a sane PC.
            pc_d    = HANDLER_PC;
            instr_d = '0;
            exc_d   = EXC_NONE;
            bd_d    = 1'b0;
        end else if (stall) begin
            // hold
        end else if (flush) begin
            // Squashed slot still carries its PC.
            pc_d    = if_pc;
            instr_d = '0;
            exc_d   = EXC_NONE;
            bd_d    = 1'b0;
        end else begin
            pc_d    = if_pc;
            instr_d = fetch_instr;
            exc_d   = fetch_exc;
            bd_d    = is_jump;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            exc_q   <= EXC_NONE;
            bd_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
        end
    end

    assign id_pc       = pc_q;
    assign id_instr    = instr_q;
    assign id_exc_code = exc_q;
    assign id_bd       = bd_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage with fetch-PC register, AdEL detection and the
// IF/ID register (if_id_reg).
// Ports:
//   clk, reset      - clock (rising edge), async active-high reset
//   stall           - hazard stall, freezes PC and IF/ID
//   req             - CP0 request, redirects fetch to HANDLER_PC
//   IF_ID_FLUSH     - Eret squash of the instruction being fetched
//   ID_NPC          - next PC from decode (sampled unmodified)
//   ID_is_jump      - decode instruction is a branch/jump
//   i_inst_rdata    - instruction memory read data (combinational)
//   i_inst_addr     - instruction memory address (= IF_PC)
//   IF_PC           - current fetch PC
//   ID_PC, ID_instr, ID_ExcCode, ID_BD - IF/ID outputs to decode
// Macro IF_RANGE_CHECK_EN: when defined, AdEL also fires for addresses
// outside [IM_LO, IM_HI]; otherwise only misalignment raises AdEL.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = PKG_RESET_PC,
    parameter logic [31:0] HANDLER_PC = PKG_HANDLER_PC
`ifdef IF_RANGE_CHECK_EN
    ,
    parameter logic [31:0] IM_LO      = PKG_IM_LO,
    parameter logic [31:0] IM_HI      = PKG_IM_HI
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        IF_ID_FLUSH,
    input  logic [31:0] ID_NPC,
    input  logic        ID_is_jump,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] IF_PC,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_instr,
    output logic [4:0]  ID_ExcCode,
    output logic        ID_BD
);

    logic [31:0] pc_d, pc_q;
    logic        adel;
    logic [31:0] fetch_instr;
    logic [4:0]  fetch_exc;

    // Flush and normal flow both load ID_NPC (EPC on Eret).
    always_comb begin
        pc_d = pc_q;
        if (req) begin
            pc_d = HANDLER_PC;
        end else if (!stall) begin
            pc_d = ID_NPC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
`ifdef IF_RANGE_CHECK_EN
        adel = is_misaligned(pc_q) || (pc_q < IM_LO) || (pc_q > IM_HI);
`else
        adel = is_misaligned(pc_q);
`endif
        fetch_instr = adel ? '0 : i_inst_rdata;
        fetch_exc   = adel ? EXC_ADEL : EXC_NONE;
    end

    if_id_reg #(
        .RESET_PC   (RESET_PC),
        .HANDLER_PC (HANDLER_PC)
    ) u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .stall       (stall),
        .flush       (IF_ID_FLUSH),
        .if_pc       (pc_q),
        .fetch_instr (fetch_instr),
        .fetch_exc   (fetch_exc),
        .is_jump     (ID_is_jump),
        .id_pc       (ID_PC),
        .id_instr    (ID_instr),
        .id_exc_code (ID_ExcCode),
        .id_bd       (ID_BD)
    );

    assign IF_PC       = pc_q;
    assign i_inst_addr = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage.
// Instruction memory model returns addr ^ 32'hDEAD_0000.
// Expectations that depend on IF_RANGE_CHECK_EN follow the same macro.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        req;
    logic        IF_ID_FLUSH;
    logic [31:0] ID_NPC;
    logic        ID_is_jump;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] IF_PC;
    logic [31:0] ID_PC;
    logic [31:0] ID_instr;
    logic [4:0]  ID_ExcCode;
    logic        ID_BD;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

`ifdef IF_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .req          (req),
        .IF_ID_FLUSH  (IF_ID_FLUSH),
        .ID_NPC       (ID_NPC),
        .ID_is_jump   (ID_is_jump),
        .i_inst_rdata (i_inst_rdata),
        .i_inst_addr  (i_inst_addr),
        .IF_PC        (IF_PC),
        .ID_PC        (ID_PC),
        .ID_instr     (ID_instr),
        .ID_ExcCode   (ID_ExcCode),
        .ID_BD        (ID_BD)
    );

    always #5 clk = ~clk;

    assign i_inst_rdata = i_inst_addr ^ 32'hDEAD_0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_if, input logic [31:0] e_idpc,
                           input logic [31:0] e_instr, input logic [4:0] e_exc, input logic e_bd);
        chk({tag, ".IF_PC"},  IF_PC, e_if);
        chk({tag, ".addr"},   i_inst_addr, e_if);
        chk({tag, ".ID_PC"},  ID_PC, e_idpc);
        chk({tag, ".instr"},  ID_instr, e_instr);
        chk({tag, ".exc"},    {27'd0, ID_ExcCode}, {27'd0, e_exc});
        chk({tag, ".bd"},     {31'd0, ID_BD}, {31'd0, e_bd});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; req = 1'b0; IF_ID_FLUSH = 1'b0;
        ID_NPC = 32'h0000_3004; ID_is_jump = 1'b0;
        #12;
        chk_all("reset", 32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0);
        reset = 1'b0;

        // sequential fetch
        ID_NPC = 32'h3004; step();
        chk_all("seq1", 32'h3004, 32'h3000, 32'hDEAD3000, 5'd0, 1'b0);
        ID_NPC = 32'h3008; step();
        chk_all("seq2", 32'h3008, 32'h3004, 32'hDEAD3004, 5'd0, 1'b0);

        // stall two cycles at 3008
        stall = 1'b1; ID_NPC = 32'h300C; step();
        chk_all("stall1", 32'h3008, 32'h3004, 32'hDEAD3004, 5'd0, 1'b0);
        step();
        chk_all("stall2", 32'h3008, 32'h3004, 32'hDEAD3004, 5'd0, 1'b0);
        stall = 1'b0; step();
        chk_all("unstall", 32'h300C, 32'h3008, 32'hDEAD3008, 5'd0, 1'b0);

        // misaligned target
        ID_NPC = 32'h3002; step();
        chk_all("mis_a", 32'h3002, 32'h300C, 32'hDEAD300C, 5'd0, 1'b0);
        ID_NPC = 32'h3010; step();
        chk_all("mis_b", 32'h3010, 32'h3002, 32'h0, 5'd4, 1'b0);

        // beq at 3010, delay slot at 3014, target 7000
        ID_NPC = 32'h3014; step();
        chk_all("beq_f", 32'h3014, 32'h3010, 32'hDEAD3010, 5'd0, 1'b0);
        ID_is_jump = 1'b1; ID_NPC = 32'h7000; step();
        chk_all("bd", 32'h7000, 32'h3014, 32'hDEAD3014, 5'd0, 1'b1);

        // out of range above IM_HI
        ID_is_jump = 1'b0; ID_NPC = 32'h6FFC; step();
        chk_all("hi_out", 32'h6FFC, 32'h7000, RC ? 32'h0 : 32'hDEAD7000, RC ? 5'd4 : 5'd0, 1'b0);
        // IM_HI itself is legal
        ID_NPC = 32'h3000; step();
        chk_all("hi_edge", 32'h3000, 32'h6FFC, 32'hDEAD6FFC, 5'd0, 1'b0);
        // IM_LO legal, then below IM_LO
        ID_NPC = 32'h2FFC; step();
        chk_all("lo_edge", 32'h2FFC, 32'h3000, 32'hDEAD3000, 5'd0, 1'b0);
        ID_NPC = 32'h3020; step();
        chk_all("lo_out", 32'h3020, 32'h2FFC, RC ? 32'h0 : 32'hDEAD2FFC, RC ? 5'd4 : 5'd0, 1'b0);

        // Eret flush to EPC 3040; ID_BD must stay clear
        IF_ID_FLUSH = 1'b1; ID_is_jump = 1'b1; ID_NPC = 32'h3040; step();
        chk_all("flush", 32'h3040, 32'h3020, 32'h0, 5'd0, 1'b0);
        IF_ID_FLUSH = 1'b0; ID_is_jump = 1'b0; ID_NPC = 32'h3044; step();
        chk_all("post_flush", 32'h3044, 32'h3040, 32'hDEAD3040, 5'd0, 1'b0);

        // flush clears a pending AdEL
        ID_NPC = 32'h3001; step();
        chk_all("mis_c", 32'h3001, 32'h3044, 32'hDEAD3044, 5'd0, 1'b0);
        IF_ID_FLUSH = 1'b1; ID_NPC = 32'h3048; step();
        chk_all("flush_adel", 32'h3048, 32'h3001, 32'h0, 5'd0, 1'b0);

        // req beats stall and flush
        req = 1'b1; stall = 1'b1; IF_ID_FLUSH = 1'b1; ID_is_jump = 1'b1; ID_NPC = 32'h5000; step();
        chk_all("req", 32'h4180, 32'h4180, 32'h0, 5'd0, 1'b0);
        req = 1'b0; IF_ID_FLUSH = 1'b0; ID_is_jump = 1'b0; ID_NPC = 32'h4184; step();
        chk_all("req_stall", 32'h4180, 32'h4180, 32'h0, 5'd0, 1'b0);
        stall = 1'b0; step();
        chk_all("handler", 32'h4184, 32'h4180, 32'hDEAD4180, 5'd0, 1'b0);

        // one more fetch so state differs from reset, then async reset
        ID_is_jump = 1'b1; ID_NPC = 32'h3100; step();
        chk_all("pre_rst", 32'h3100, 32'h4184, 32'hDEAD4184, 5'd0, 1'b1);
        reset = 1'b1;
        #2;
        chk_all("async_rst", 32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
